// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Stream-to-register bridge in front of a CPU-style UART register port.
//   Outgoing bytes are buffered in a TX FIFO and incoming bytes in an RX FIFO.
//   The bridge polls the UART status register. It reads a received byte when
//   rx_full is set and there is room in the RX FIFO. Otherwise it writes the
//   TX FIFO head when the transmitter is idle. Every bus access is followed by
//   a GAP of POLL_GAP+1 idle cycles before the next status poll.
//
// Ports
//   clk, reset            clock shared with the UART; asynchronous active-high reset
//   tx_data/valid/ready   byte stream into the TX FIFO
//   rx_data/valid/ready   byte stream out of the RX FIFO (rx_data = head, 0 when empty)
//   tx_level, rx_level    FIFO occupancies, 0..DEPTH
//   bus_cs_b, bus_rnw     UART chip select (active-low), 1 = read / 0 = write
//   bus_a0                0 = status register, 1 = data register
//   bus_din               write data to the UART
//   bus_dout              UART read data (status: bit7 tx_busy, bit6 rx_full)
module uart_bus_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int POLL_GAP = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(TX_DEPTH):0]    tx_level,
  output logic [$clog2(RX_DEPTH):0]    rx_level,
  output logic                         bus_cs_b,
  output logic                         bus_rnw,
  output logic                         bus_a0,
  output logic [7:0]                   bus_din,
  input  logic [7:0]                   bus_dout
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [7:0]     GAP_INIT = 8'(POLL_GAP);
  localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {ST_GAP, ST_POLL, ST_RXRD, ST_TXWR} state_t;

  state_t     state, state_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;

  // TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_cnt;
  logic             txf_full, txf_empty, tx_push, tx_pop;

  assign txf_full  = (tx_cnt == TX_FULL_LVL);
  assign txf_empty = (tx_cnt == '0);
  assign tx_ready  = !txf_full;
  assign tx_level  = tx_cnt;
  assign tx_push   = tx_valid && !txf_full;
  // TXWR is only entered with a non-empty FIFO, so the pop needs no guard.
  assign tx_pop    = (state == ST_TXWR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= tx_data;
  end

  // RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_cnt;
  logic             rxf_full, rxf_empty, rx_push, rx_pop;

  assign rxf_full  = (rx_cnt == RX_FULL_LVL);
  assign rxf_empty = (rx_cnt == '0);
  assign rx_valid  = !rxf_empty;
  assign rx_level  = rx_cnt;
  assign rx_data   = rxf_empty ? 8'h00 : rx_mem[rx_rp];
  assign rx_push   = (state == ST_RXRD) && !rxf_full;
  assign rx_pop    = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= bus_dout;
  end

  // Access sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_GAP;
      gap_cnt <= GAP_INIT;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_nxt = ST_POLL;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end
      ST_POLL: begin
        gap_cnt_nxt = GAP_INIT;
        // Receive side wins so the UART receiver is drained before it overruns.
        if (bus_dout[6] && !rxf_full)       state_nxt = ST_RXRD;
        else if (!bus_dout[7] && !txf_empty) state_nxt = ST_TXWR;
        else                                 state_nxt = ST_GAP;
      end
      ST_RXRD: begin
        gap_cnt_nxt = GAP_INIT;
        state_nxt   = ST_GAP;
      end
      ST_TXWR: begin
        gap_cnt_nxt = GAP_INIT;
        state_nxt   = ST_GAP;
      end
      default: begin
        gap_cnt_nxt = GAP_INIT;
        state_nxt   = ST_GAP;
      end
    endcase
  end

  // Bus outputs depend only on the state register and the TX FIFO head, so the
  // asynchronous reset returns the bus to idle immediately.
  always_comb begin
    bus_cs_b = (state == ST_GAP);
    bus_rnw  = (state != ST_TXWR);
    bus_a0   = (state == ST_RXRD) || (state == ST_TXWR);
    bus_din  = (state == ST_TXWR) ? tx_mem[tx_rp] : 8'h00;
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] tx_level, rx_level;
  logic       bus_cs_b, bus_rnw, bus_a0;
  logic [7:0] bus_din, bus_dout;

  // second instance with POLL_GAP=3 for the reset-during-write case
  logic       reset3 = 1'b1;
  logic [7:0] tx_data3 = 8'h00;
  logic       tx_valid3 = 1'b0;
  logic       tx_ready3;
  logic [7:0] rx_data3;
  logic       rx_valid3;
  logic       rx_ready3 = 1'b0;
  logic [4:0] tx_level3, rx_level3;
  logic       bus_cs_b3, bus_rnw3, bus_a03;
  logic [7:0] bus_din3;
  logic [7:0] bus_dout3 = 8'h00;

  always #5 clk = ~clk;

  uart_bus_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .POLL_GAP(0)) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level),
    .bus_cs_b(bus_cs_b), .bus_rnw(bus_rnw), .bus_a0(bus_a0),
    .bus_din(bus_din), .bus_dout(bus_dout)
  );

  uart_bus_bridge #(.TX_DEPTH(16), .RX_DEPTH(16), .POLL_GAP(3)) dut3 (
    .clk(clk), .reset(reset3),
    .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3),
    .rx_data(rx_data3), .rx_valid(rx_valid3), .rx_ready(rx_ready3),
    .tx_level(tx_level3), .rx_level(rx_level3),
    .bus_cs_b(bus_cs_b3), .bus_rnw(bus_rnw3), .bus_a0(bus_a03),
    .bus_din(bus_din3), .bus_dout(bus_dout3)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // UART model: status = {tx_busy, rx_full, 6'b0}; data register = received byte.
  logic [7:0] src_q[$];       // bytes the UART will "receive"
  logic       force_busy = 1'b0;
  logic       fb_q = 1'b0;    // registered so forced busy changes on an edge
  logic       u_busy = 1'b0;
  logic [3:0] u_bcnt = 4'd0;
  logic       u_full = 1'b0;
  logic [7:0] u_byte = 8'h00;

  assign bus_dout = bus_a0 ? u_byte : {(u_busy | fb_q), u_full, 6'b000000};

  always @(posedge clk) begin
    fb_q <= force_busy;
    if (!bus_cs_b && !bus_rnw && bus_a0) begin
      u_busy <= 1'b1;
      u_bcnt <= 4'd6;
    end else if (u_bcnt != 4'd0) begin
      u_bcnt <= u_bcnt - 4'd1;
      if (u_bcnt == 4'd1) u_busy <= 1'b0;
    end
    if (!bus_cs_b && bus_rnw && bus_a0) begin
      u_full <= 1'b0;
    end else if (!u_full && src_q.size() != 0) begin
      u_byte <= src_q.pop_front();
      u_full <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues and monitor
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int wr_count = 0, rd_count = 0, rxv_cycles = 0;
  int wr_cyc = 0, rd_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (!bus_cs_b && !bus_rnw) begin
        wr_count++;
        wr_cyc = cyc;
        chk("tx_wr_a0", 32'(bus_a0), 32'd1);
        chk("tx_wr_while_busy", 32'(u_busy | fb_q), 32'd0);
        if (exp_tx.size() == 0) chk("tx_wr_unexpected", 32'(bus_din), 32'hFFFF_FFFF);
        else chk("tx_wr_data", 32'(bus_din), 32'(exp_tx.pop_front()));
      end
      if (!bus_cs_b && bus_rnw && bus_a0) begin
        rd_count++;
        rd_cyc = cyc;
        chk("rx_rd_without_full", 32'(u_full), 32'd1);
      end
      if (rx_valid) rxv_cycles++;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int rd0, rxv0, c0, i;

    // Reset values
    tick(); tick();
    chk("rst_cs_b", 32'(bus_cs_b), 32'd1);
    chk("rst_rnw", 32'(bus_rnw), 32'd1);
    chk("rst_a0", 32'(bus_a0), 32'd0);
    chk("rst_din", 32'(bus_din), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_level", 32'(tx_level), 32'd0);
    chk("rst_rx_level", 32'(rx_level), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    reset  = 1'b0;
    reset3 = 1'b0;

    // Idle polling: POLL every 2nd cycle, status register only
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("idle_cs_b", 32'(bus_cs_b), (k % 2 == 1) ? 32'd0 : 32'd1);
      chk("idle_a0", 32'(bus_a0), 32'd0);
    end

    // Two TX bytes; the second waits for tx_busy to drop
    force_busy = 1'b1;
    tick();
    tx_valid = 1'b1; tx_data = 8'h55; exp_tx.push_back(8'h55);
    tick();
    tx_data = 8'hA3; exp_tx.push_back(8'hA3);
    tick();
    tx_valid = 1'b0;
    chk("tx_level_2", 32'(tx_level), 32'd2);
    force_busy = 1'b0;
    for (i = 0; i < 10 && tx_level != 5'd1; i++) tick();
    chk("tx_level_1", 32'(tx_level), 32'd1);
    tick(); tick(); tick(); tick();
    chk("tx_level_1_held_busy", 32'(tx_level), 32'd1);
    for (i = 0; i < 40 && tx_level != 5'd0; i++) tick();
    chk("tx_level_0", 32'(tx_level), 32'd0);
    chk("tx_all_written", 32'(exp_tx.size()), 32'd0);

    // Single RX byte
    rd0 = rd_count; rxv0 = rxv_cycles;
    rx_ready = 1'b1;
    src_q.push_back(8'h3C); exp_rx.push_back(8'h3C);
    for (i = 0; i < 20 && rd_count == rd0; i++) tick();
    chk("rx_one_read", 32'(rd_count - rd0), 32'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("rx_no_second_read", 32'(rd_count - rd0), 32'd1);
    chk("rx_valid_one_cycle", 32'(rxv_cycles - rxv0), 32'd1);
    chk("rx_drained", 32'(exp_rx.size()), 32'd0);

    // RX and TX pending together: read first, both done within 6 cycles
    force_busy = 1'b1;
    tick(); tick();
    tx_valid = 1'b1; tx_data = 8'h81; exp_tx.push_back(8'h81);
    tick();
    tx_valid = 1'b0;
    tick(); tick();
    force_busy = 1'b0;
    src_q.push_back(8'h42); exp_rx.push_back(8'h42);
    c0 = cyc;
    for (i = 0; i < 12 && (exp_tx.size() != 0 || exp_rx.size() != 0); i++) tick();
    chk("prio_both_done", 32'(exp_tx.size() + exp_rx.size()), 32'd0);
    chk("prio_rd_before_wr", 32'(rd_cyc < wr_cyc && rd_cyc > c0), 32'd1);
    chk("prio_within_6", 32'(wr_cyc - c0 <= 6), 32'd1);

    // Fill RX FIFO with consumer stalled; reads stop at 16, order preserved
    rx_ready = 1'b0;
    tick();
    for (int k = 0; k < 17; k++) begin
      src_q.push_back(8'h10 + 8'(k));
      exp_rx.push_back(8'h10 + 8'(k));
    end
    for (i = 0; i < 200 && rx_level != 5'd16; i++) tick();
    chk("rx_level_16", 32'(rx_level), 32'd16);
    rd0 = rd_count;
    for (int k = 0; k < 10; k++) tick();
    chk("rx_full_no_read", 32'(rd_count - rd0), 32'd0);
    chk("rx_level_16_held", 32'(rx_level), 32'd16);
    chk("uart_still_full", 32'(u_full), 32'd1);
    rx_ready = 1'b1;
    for (i = 0; i < 300 && exp_rx.size() != 0; i++) tick();
    chk("rx_fill_drained", 32'(exp_rx.size()), 32'd0);
    tick();
    chk("rx_level_0", 32'(rx_level), 32'd0);

    // POLL_GAP=3: reset in the middle of a TX write
    tx_valid3 = 1'b1; tx_data3 = 8'h99;
    tick();
    tx_valid3 = 1'b0;
    for (i = 0; i < 20 && !(!bus_cs_b3 && !bus_rnw3); i++) tick();
    chk("g3_txwr_seen", 32'(!bus_cs_b3 && !bus_rnw3), 32'd1);
    #2;
    reset3 = 1'b1;
    #1;
    chk("g3_rst_cs_b", 32'(bus_cs_b3), 32'd1);
    chk("g3_rst_rnw", 32'(bus_rnw3), 32'd1);
    chk("g3_rst_din", 32'(bus_din3), 32'd0);
    chk("g3_rst_tx_level", 32'(tx_level3), 32'd0);
    chk("g3_rst_tx_ready", 32'(tx_ready3), 32'd1);
    tick();
    reset3 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("g3_first_poll", 32'(bus_cs_b3), (k == 4) ? 32'd0 : 32'd1);
    end

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
